// File: rtl/keypad_scanner_pkg.sv
// Shared constants, FSM encoding and bit-vector helpers for the 4x4 keypad scanner.
package keypad_scanner_pkg;

  localparam int NUM_COLS  = 4;
  localparam int NUM_ROWS  = 4;
  localparam int NUM_KEYS  = NUM_COLS * NUM_ROWS;
  localparam int CODE_W    = 4;
  localparam int COL_IDX_W = 2;

  localparam logic [1:0] ST_RELEASED = 2'd0;
  localparam logic [1:0] ST_ONE      = 2'd1;
  localparam logic [1:0] ST_MULTI    = 2'd2;

  localparam logic [NUM_COLS-1:0] COL_RESET = 4'b1110;

  function automatic logic [4:0] popcount16(input logic [NUM_KEYS-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      n = n + {4'b0000, v[i]};
    end
    return n;
  endfunction

  // Only meaningful when exactly one bit is set; the highest set bit wins otherwise.
  function automatic logic [CODE_W-1:0] onehot_index(input logic [NUM_KEYS-1:0] v);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (v[i]) idx = CODE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Whole-snapshot debouncer: commits a snapshot once it has repeated DEBOUNCE_SCANS times.
// commit is a one-cycle strobe registered alongside the new debounced value.
module key_debounce #(
  parameter int WIDTH          = 16,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample,
  input  logic [WIDTH-1:0] snap,
  output logic [WIDTH-1:0] debounced,
  output logic             commit
);

  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

  logic [WIDTH-1:0] candidate;
  logic [CNT_W-1:0] stable_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             differ;
  logic             first_hit;

  always_comb begin
    differ = (snap != candidate);
    if (differ)
      cnt_nxt = CNT_W'(1);
    else if (stable_cnt == CNT_MAX)
      cnt_nxt = stable_cnt;
    else
      cnt_nxt = stable_cnt + CNT_W'(1);
    // A saturated count only re-commits if the snapshot actually changed.
    first_hit = (cnt_nxt == CNT_MAX) && (differ || (stable_cnt != CNT_MAX));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      candidate  <= '0;
      stable_cnt <= '0;
      debounced  <= '0;
      commit     <= 1'b0;
    end else begin
      commit <= 1'b0;
      if (sample) begin
        candidate  <= snap;
        stable_cnt <= cnt_nxt;
        if (first_hit) begin
          debounced <= snap;
          commit    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column strobing, row sync, debounce, single-key FSM and valid/ack event port.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV       = 8,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_ROWS-1:0] key_row,
  output logic [NUM_COLS-1:0] key_col,
  output logic [CODE_W-1:0]   key_code,
  output logic                key_valid,
  input  logic                key_ack,
  output logic                key_pressed,
  output logic                overrun
);

  localparam int DWELL_W = $clog2(SCAN_DIV);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);

  logic [NUM_ROWS-1:0]  row_meta;
  logic [NUM_ROWS-1:0]  row_sync;
  logic [DWELL_W-1:0]   dwell;
  logic [COL_IDX_W-1:0] col_idx;
  logic [NUM_KEYS-1:0]  snapshot;
  logic [NUM_KEYS-1:0]  snap_next;
  logic [NUM_KEYS-1:0]  debounced;
  logic                 commit;
  logic                 dwell_end;
  logic                 scan_done;
  logic [1:0]           state;
  logic [1:0]           state_nxt;
  logic                 emit;
  logic [4:0]           pc;

  assign dwell_end = (dwell == DWELL_LAST);
  assign scan_done = dwell_end && (col_idx == COL_IDX_W'(NUM_COLS - 1));

  always_comb begin
    snap_next = snapshot;
    snap_next[{col_idx, 2'b00} +: NUM_ROWS] = ~row_sync;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_meta <= '1;
      row_sync <= '1;
      dwell    <= '0;
      col_idx  <= '0;
      key_col  <= COL_RESET;
      snapshot <= '0;
    end else begin
      row_meta <= key_row;
      row_sync <= row_meta;
      if (dwell_end) begin
        dwell    <= '0;
        col_idx  <= col_idx + COL_IDX_W'(1);
        key_col  <= {key_col[NUM_COLS-2:0], key_col[NUM_COLS-1]};
        snapshot <= snap_next;
      end else begin
        dwell <= dwell + DWELL_W'(1);
      end
    end
  end

  // Debounce sees the snapshot including the column being sampled on this edge.
  key_debounce #(
    .WIDTH          (NUM_KEYS),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_debounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .sample    (scan_done),
    .snap      (snap_next),
    .debounced (debounced),
    .commit    (commit)
  );

  assign pc = popcount16(debounced);

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    if (commit) begin
      case (state)
        ST_RELEASED: begin
          if (pc == 5'd1) begin
            state_nxt = ST_ONE;
            emit      = 1'b1;
          end else if (pc >= 5'd2) begin
            state_nxt = ST_MULTI;
          end
        end
        ST_ONE:  state_nxt = (pc == 5'd0) ? ST_RELEASED : ST_MULTI;
        default: if (pc == 5'd0) state_nxt = ST_RELEASED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_RELEASED;
      key_code  <= '0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (emit) begin
        if (!key_valid || key_ack) begin
          key_code  <= onehot_index(debounced);
          key_valid <= 1'b1;
          if (key_ack) overrun <= 1'b0;
        end else begin
          overrun <= 1'b1;
        end
      end else if (key_ack && key_valid) begin
        key_valid <= 1'b0;
        overrun   <= 1'b0;
      end
    end
  end

  assign key_pressed = (state == ST_ONE);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a key-matrix model drives rows from the column strobes.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  key_row;
  logic [3:0]  key_col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ack;
  logic        key_pressed;
  logic        overrun;
  logic [15:0] keys;

  int checks  = 0;
  int errors  = 0;
  int evt_cnt = 0;
  logic valid_q = 1'b0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_row     (key_row),
    .key_col     (key_col),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_ack     (key_ack),
    .key_pressed (key_pressed),
    .overrun     (overrun)
  );

  // A pressed key shorts its row low while its column is strobed.
  always_comb begin
    key_row = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!key_col[c] && keys[c*4+r]) key_row[r] = 1'b0;
  end

  always @(posedge clk) begin
    #1;
    if (key_valid && !valid_q) evt_cnt++;
    valid_q = key_valid;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench at the negedge right after key_col wraps to column 0.
  task automatic align_scan();
    int guard;
    guard = 0;
    while (key_col !== 4'b0111 && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    while (key_col !== 4'b1110 && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    chk("align_col0", key_col, 4'b1110);
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int n;
    n = 0;
    while (!key_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, key_valid, 1);
  endtask

  task automatic ack_pulse(input string tag);
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
    chk(tag, key_valid, 0);
  endtask

  logic [3:0] col_pat [4];
  int e0;

  initial begin
    col_pat = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    keys    = '0;
    key_ack = 1'b0;
    rst_n   = 1'b0;
    cycles(3);
    chk("rst_col",     key_col, 4'b1110);
    chk("rst_valid",   key_valid, 0);
    chk("rst_code",    key_code, 0);
    chk("rst_pressed", key_pressed, 0);
    chk("rst_overrun", overrun, 0);

    rst_n = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      chk("col_rotate", key_col, col_pat[(n/4)%4]);
    end

    cycles(6);
    chk("pre_rst_col", key_col, 4'b1101);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midscan_rst_col", key_col, 4'b1110);
    rst_n = 1'b1;

    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      chk("idle_quiet", {key_valid, key_pressed}, 0);
    end

    // Single key 6 (col 1, row 2), pressed at a scan start.
    align_scan();
    keys = 16'h0040;
    wait_valid(51, "k6_latency");
    chk("k6_code", key_code, 6);
    chk("k6_pressed", key_pressed, 1);
    e0 = evt_cnt;
    cycles(200);
    chk("k6_hold_code", key_code, 6);
    chk("k6_hold_valid", key_valid, 1);
    chk("k6_no_second_evt", evt_cnt, e0);
    chk("k6_no_overrun", overrun, 0);
    ack_pulse("k6_ack");
    keys = '0;
    cycles(80);
    chk("k6_released", key_pressed, 0);

    // Bounce on key 0: no two consecutive scans agree until the hold.
    align_scan();
    e0 = evt_cnt;
    for (int i = 0; i < 12; i++) begin
      keys = (i % 2 == 0) ? 16'h0001 : 16'h0000;
      cycles(5);
    end
    keys = 16'h0001;
    cycles(20);
    chk("bounce_not_early", key_valid, 0);
    cycles(60);
    chk("bounce_valid", key_valid, 1);
    chk("bounce_code", key_code, 0);
    chk("bounce_one_evt", evt_cnt - e0, 1);
    ack_pulse("bounce_ack");
    keys = '0;
    cycles(80);

    // Rollover: keys 0 and 5 together, then partial release.
    e0 = evt_cnt;
    keys = 16'h0021;
    cycles(100);
    chk("ghost_no_evt", evt_cnt, e0);
    chk("ghost_pressed", key_pressed, 0);
    keys = 16'h0001;
    cycles(100);
    chk("multi_hold_no_evt", evt_cnt, e0);
    chk("multi_hold_pressed", key_pressed, 0);
    keys = '0;
    cycles(100);
    keys = 16'h8000;
    wait_valid(100, "k15_valid");
    chk("k15_code", key_code, 15);
    chk("k15_pressed", key_pressed, 1);
    ack_pulse("k15_ack");
    keys = '0;
    cycles(80);

    // Overrun: key 3 pending, key 9 dropped.
    keys = 16'h0008;
    wait_valid(100, "k3_valid");
    chk("k3_code", key_code, 3);
    keys = '0;
    cycles(80);
    keys = 16'h0200;
    cycles(100);
    chk("ovr_code_kept", key_code, 3);
    chk("ovr_valid", key_valid, 1);
    chk("ovr_flag", overrun, 1);
    ack_pulse("ovr_ack_valid");
    chk("ovr_ack_clear", overrun, 0);
    keys = '0;
    cycles(80);

    // Re-arm a pending event plus overrun, then ack exactly on the key 12 event edge.
    keys = 16'h0002;
    wait_valid(100, "k1_valid");
    chk("k1_code", key_code, 1);
    keys = '0;
    cycles(80);
    keys = 16'h0004;
    cycles(100);
    chk("k2_overrun", overrun, 1);
    keys = '0;
    cycles(80);
    align_scan();
    keys = 16'h1000;
    cycles(32);
    chk("k12_pre_code", key_code, 1);
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
    chk("k12_same_edge_valid", key_valid, 1);
    chk("k12_same_edge_code", key_code, 12);
    chk("k12_same_edge_ovr", overrun, 0);
    ack_pulse("k12_final_ack");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
